// File: rtl/trigger_capture_if.sv
// rtl/trigger_capture_if.sv - sample stream and Pi serial link bundle for trigger_capture
// Signals:
//   sample_valid   one-cycle strobe, sample_data holds a new sample
//   sample_data    8-bit sample byte from the ADC serial sampler
//   pi_clk         asynchronous bit clock driven by the Pi
//   pi_data        serial record data, MSB first
//   pi_signal_flag high while a captured record is available for readout
// Modports: master = sampler/Pi side, slave = trigger_capture.

interface trigger_capture_if;
  logic       sample_valid;
  logic [7:0] sample_data;
  logic       pi_clk;
  logic       pi_data;
  logic       pi_signal_flag;

  modport master (
    output sample_valid,
    output sample_data,
    output pi_clk,
    input  pi_data,
    input  pi_signal_flag
  );

  modport slave (
    input  sample_valid,
    input  sample_data,
    input  pi_clk,
    output pi_data,
    output pi_signal_flag
  );
endinterface

// File: rtl/trigger_capture.sv
// rtl/trigger_capture.sv - circular sample buffer with rising-level trigger and serial Pi readout
// Ports:
//   osc_clk     sole clock
//   reset       synchronous, active-high
//   trig_level  unsigned trigger threshold
//   arm         level; requests a capture
//   capturing   high while in PRETRIG, ARMED or POST
//   bus         trigger_capture_if.slave: sample stream in, Pi clock in, Pi data/flag out
// Parameters:
//   DEPTH       buffer depth in samples (power of 2, >= 16)
//   PRETRIG     samples kept before the trigger sample (1 <= PRETRIG < DEPTH)

module trigger_capture #(
  parameter int DEPTH   = 1024,
  parameter int PRETRIG = 256
) (
  input  logic             osc_clk,
  input  logic             reset,
  input  logic [7:0]       trig_level,
  input  logic             arm,
  output logic             capturing,
  trigger_capture_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] PRE_OFF   = AW'(PRETRIG);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRETRIG - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRETRIG - 1);
  localparam logic [AW-1:0] BYTE_LAST = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRETRIG,
    S_ARMED,
    S_POST,
    S_LOAD,
    S_READOUT
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_rdata;
  logic          ram_we;

  logic [AW-1:0] wptr;
  logic [AW-1:0] pre_cnt;
  logic [AW-1:0] post_cnt;
  logic [AW-1:0] trig_ptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] byte_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    prev;
  logic [7:0]    shift;
  logic [7:0]    prefetch;
  logic [AW-1:0] load_addr;

  logic pi_s1, pi_s2, pi_s3;
  logic pi_rise;
  logic trig_hit;
  logic last_bit;
  logic readout;

  // Two-flop synchronizer plus edge register. Left unreset so it keeps
  // tracking pi_clk through reset; the edge is only used in READOUT.
  always_ff @(posedge osc_clk) begin
    pi_s1 <= bus.pi_clk;
    pi_s2 <= pi_s1;
    pi_s3 <= pi_s2;
  end

  assign pi_rise  = pi_s2 & ~pi_s3;
  assign trig_hit = bus.sample_valid && (prev < trig_level) && (bus.sample_data >= trig_level);
  assign last_bit = pi_rise && (bit_cnt == 3'd7) && (byte_cnt == BYTE_LAST);

  // Oldest byte of the record sits PRETRIG slots behind the trigger sample.
  assign load_addr = trig_ptr - PRE_OFF;

  // Single address port: writes while capturing, the record start in LOAD,
  // and the next byte (prefetch) during READOUT.
  always_comb begin
    ram_addr = wptr;
    if (state_q == S_LOAD) begin
      ram_addr = load_addr;
    end else if (state_q == S_READOUT) begin
      ram_addr = rptr + ADDR_ONE;
    end
  end

  assign ram_rdata = mem[ram_addr];

  always_ff @(posedge osc_clk) begin
    if (ram_we) begin
      mem[ram_addr] <= bus.sample_data;
    end
  end

  always_ff @(posedge osc_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ram_we    = 1'b0;
    capturing = 1'b0;
    readout   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_PRETRIG;
        end
      end
      S_PRETRIG: begin
        capturing = 1'b1;
        if (!arm) begin
          state_d = S_IDLE;
        end else if (bus.sample_valid) begin
          ram_we = 1'b1;
          if (pre_cnt == PRE_LAST) begin
            state_d = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        capturing = 1'b1;
        // Dropping arm takes priority over a trigger on the same sample.
        if (!arm) begin
          state_d = S_IDLE;
        end else if (bus.sample_valid) begin
          ram_we = 1'b1;
          if (trig_hit) begin
            state_d = (POST_LAST == '0) ? S_LOAD : S_POST;
          end
        end
      end
      S_POST: begin
        capturing = 1'b1;
        if (bus.sample_valid) begin
          ram_we = 1'b1;
          if (post_cnt == POST_LAST) begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        state_d = S_READOUT;
      end
      S_READOUT: begin
        readout = 1'b1;
        if (last_bit) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge osc_clk) begin
    if (reset) begin
      wptr     <= '0;
      pre_cnt  <= '0;
      post_cnt <= '0;
      trig_ptr <= '0;
      rptr     <= '0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      prev     <= '0;
      shift    <= '0;
      prefetch <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            wptr    <= '0;
            pre_cnt <= '0;
          end
        end
        S_PRETRIG: begin
          if (bus.sample_valid) begin
            prev <= bus.sample_data;
            if (arm) begin
              wptr    <= wptr + ADDR_ONE;
              pre_cnt <= pre_cnt + ADDR_ONE;
            end
          end
        end
        S_ARMED: begin
          if (bus.sample_valid) begin
            prev <= bus.sample_data;
            if (arm) begin
              wptr <= wptr + ADDR_ONE;
              if (trig_hit) begin
                trig_ptr <= wptr;
                post_cnt <= ADDR_ONE;
              end
            end
          end
        end
        S_POST: begin
          if (bus.sample_valid) begin
            prev     <= bus.sample_data;
            wptr     <= wptr + ADDR_ONE;
            post_cnt <= post_cnt + ADDR_ONE;
          end
        end
        S_LOAD: begin
          rptr     <= load_addr;
          shift    <= ram_rdata;
          bit_cnt  <= '0;
          byte_cnt <= '0;
        end
        S_READOUT: begin
          // Prefetch refreshes every cycle; pi_clk phases are long enough
          // that it holds rptr+1 well before the byte boundary.
          prefetch <= ram_rdata;
          if (pi_rise) begin
            if (bit_cnt == 3'd7) begin
              shift    <= prefetch;
              rptr     <= rptr + ADDR_ONE;
              byte_cnt <= byte_cnt + ADDR_ONE;
              bit_cnt  <= '0;
            end else begin
              shift   <= {shift[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.pi_signal_flag = readout;
  assign bus.pi_data        = readout & shift[7];

endmodule
